// File: rtl/operand_bypass_unit.sv
// EX-stage operand bypass for the RV32 5-stage pipeline: in-flight rd tags, load-use detect, forward selects.
// Optional macro BYPASS_PERF_CNT_EN adds load-use and forward event counters.
module operand_bypass_unit #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int REG_AW  = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_rd_we,
  input  logic                      id_is_load,
  input  logic                      pipe_stall,
  input  logic                      flush_ex,
  input  logic [NUM_SRC*XLEN-1:0]   ex_rs_data,
  input  logic [XLEN-1:0]           alu_result_mem,
  input  logic [XLEN-1:0]           result_wb,
  output logic [NUM_SRC*XLEN-1:0]   ex_op_data,
  output logic [NUM_SRC*2-1:0]      forward_sel,
`ifdef BYPASS_PERF_CNT_EN
  output logic [31:0]               perf_load_use_cnt,
  output logic [31:0]               perf_fwd_cnt,
`endif
  output logic                      load_use_stall
);

  localparam logic [1:0] FORWARD_NONE     = 2'd0;
  localparam logic [1:0] FORWARD_FROM_WB  = 2'd1;
  localparam logic [1:0] FORWARD_FROM_MEM = 2'd2;

  // The WB tag is never forwarded from (write-first register file), and MEM never
  // needs is_load, so only the fields that feed a decision are kept.
  logic                 ex_valid_reg, ex_we_reg, ex_load_reg;
  logic [REG_AW-1:0]    ex_rd_reg;
  logic                 mem_valid_reg, mem_we_reg;
  logic [REG_AW-1:0]    mem_rd_reg;
  logic [NUM_SRC*2-1:0] forward_sel_reg;
  logic [NUM_SRC*2-1:0] forward_sel_next;
  logic [NUM_SRC-1:0]   ex_match, mem_match;
  logic                 ex_fwd_ok, mem_fwd_ok, take_id;

  assign ex_fwd_ok  = ex_valid_reg  & ex_we_reg  & (ex_rd_reg  != '0);
  assign mem_fwd_ok = mem_valid_reg & mem_we_reg & (mem_rd_reg != '0);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      logic [REG_AW-1:0] rs;
      logic [1:0]        sel;
      assign rs  = id_rs[gi*REG_AW +: REG_AW];
      assign sel = forward_sel_reg[gi*2 +: 2];
      assign ex_match[gi]  = ex_fwd_ok  && (rs == ex_rd_reg);
      assign mem_match[gi] = mem_fwd_ok && (rs == mem_rd_reg);
      // EX entry is newest, so it outranks MEM on a double match.
      assign forward_sel_next[gi*2 +: 2] = ex_match[gi]  ? FORWARD_FROM_MEM :
                                           mem_match[gi] ? FORWARD_FROM_WB  : FORWARD_NONE;
      assign ex_op_data[gi*XLEN +: XLEN] = (sel == FORWARD_FROM_WB)  ? result_wb      :
                                           (sel == FORWARD_FROM_MEM) ? alu_result_mem :
                                           ex_rs_data[gi*XLEN +: XLEN];
    end
  endgenerate

  assign load_use_stall = id_valid & ex_load_reg & (|ex_match);
  assign take_id        = id_valid & ~load_use_stall & ~flush_ex;
  assign forward_sel    = forward_sel_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_reg    <= 1'b0;
      ex_we_reg       <= 1'b0;
      ex_load_reg     <= 1'b0;
      ex_rd_reg       <= '0;
      mem_valid_reg   <= 1'b0;
      mem_we_reg      <= 1'b0;
      mem_rd_reg      <= '0;
      forward_sel_reg <= '0;
    end else if (!pipe_stall) begin
      mem_valid_reg   <= ex_valid_reg;
      mem_we_reg      <= ex_we_reg;
      mem_rd_reg      <= ex_rd_reg;
      ex_valid_reg    <= take_id;
      ex_we_reg       <= id_rd_we;
      ex_load_reg     <= take_id & id_is_load;
      ex_rd_reg       <= id_rd;
      forward_sel_reg <= take_id ? forward_sel_next : '0;
    end
  end

`ifdef BYPASS_PERF_CNT_EN
  logic [31:0] perf_load_use_cnt_reg, perf_fwd_cnt_reg;
  logic [1:0]  fwd_new_cnt;

  always_comb begin
    fwd_new_cnt = 2'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd_new_cnt = fwd_new_cnt + {1'b0, (|forward_sel_next[i*2 +: 2])};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_load_use_cnt_reg <= '0;
      perf_fwd_cnt_reg      <= '0;
    end else if (!pipe_stall) begin
      if (load_use_stall) perf_load_use_cnt_reg <= perf_load_use_cnt_reg + 32'd1;
      if (take_id)        perf_fwd_cnt_reg      <= perf_fwd_cnt_reg + {30'd0, fwd_new_cnt};
    end
  end

  assign perf_load_use_cnt = perf_load_use_cnt_reg;
  assign perf_fwd_cnt      = perf_fwd_cnt_reg;
`endif

endmodule

// File: tb/tb_operand_bypass_unit.sv
// Directed bench for operand_bypass_unit: expected selects queued at issue, checked after the ID->EX edge.
module tb_operand_bypass_unit;

  localparam logic [31:0] RS0_V = 32'h1234_5678;
  localparam logic [31:0] RS1_V = 32'h1111_2222;
  localparam logic [31:0] MEM_V = 32'hDEAD_BEEF;
  localparam logic [31:0] WB_V  = 32'hCAFE_0001;

  logic        clk = 1'b0;
  logic        rst, id_valid, id_rd_we, id_is_load, pipe_stall, flush_ex;
  logic [9:0]  id_rs;
  logic [4:0]  id_rd;
  logic [63:0] ex_rs_data;
  logic [31:0] alu_result_mem, result_wb;
  logic [63:0] ex_op_data;
  logic [3:0]  forward_sel;
  logic        load_use_stall;
`ifdef BYPASS_PERF_CNT_EN
  logic [31:0] perf_load_use_cnt, perf_fwd_cnt;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      tag;
    logic [3:0] sel;
  } exp_t;
  exp_t exp_q[$];

  operand_bypass_unit #(.XLEN(32), .NUM_SRC(2), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rd(id_rd),
    .id_rd_we(id_rd_we), .id_is_load(id_is_load), .pipe_stall(pipe_stall),
    .flush_ex(flush_ex), .ex_rs_data(ex_rs_data), .alu_result_mem(alu_result_mem),
    .result_wb(result_wb), .ex_op_data(ex_op_data), .forward_sel(forward_sel),
`ifdef BYPASS_PERF_CNT_EN
    .perf_load_use_cnt(perf_load_use_cnt), .perf_fwd_cnt(perf_fwd_cnt),
`endif
    .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] exp_data(input logic [3:0] sel);
    logic [63:0] r;
    logic [1:0]  s;
    r = '0;
    for (int i = 0; i < 2; i++) begin
      s = sel[i*2 +: 2];
      case (s)
        2'd1:    r[i*32 +: 32] = WB_V;
        2'd2:    r[i*32 +: 32] = MEM_V;
        default: r[i*32 +: 32] = (i == 0) ? RS0_V : RS1_V;
      endcase
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_underflow observed=0 expected=1");
    end else begin
      e = exp_q.pop_front();
      check({e.tag, "/sel"}, 64'(forward_sel), 64'(e.sel));
      check({e.tag, "/data"}, ex_op_data, exp_data(e.sel));
      $display("txn %-12s forward_sel=%h ex_op_data=%h stall=%0d", e.tag, forward_sel, ex_op_data,
               load_use_stall);
    end
  endtask

  // Drive one ID slot, check the combinational stall, then check the registered select after the edge.
  task automatic issue(input string tag, input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic we, input logic ld, input logic fl,
                       input logic ps, input logic exp_lu, input logic [3:0] exp_sel);
    exp_t e;
    id_valid   = v;
    id_rs      = {rs2, rs1};
    id_rd      = rd;
    id_rd_we   = we;
    id_is_load = ld;
    flush_ex   = fl;
    pipe_stall = ps;
    #1;
    check({tag, "/lu"}, 64'(load_use_stall), 64'(exp_lu));
    e.tag = tag;
    e.sel = exp_sel;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; id_valid = 1'b0; id_rs = '0; id_rd = '0; id_rd_we = 1'b0; id_is_load = 1'b0;
    pipe_stall = 1'b0; flush_ex = 1'b0;
    ex_rs_data = {RS1_V, RS0_V}; alu_result_mem = MEM_V; result_wb = WB_V;

    repeat (2) @(posedge clk);
    #1;
    check("reset/lu", 64'(load_use_stall), 64'd0);
    e.tag = "reset"; e.sel = 4'h0; exp_q.push_back(e);
    pop_check();
    rst = 1'b0;
    @(posedge clk);
    #1;
    e.tag = "post_reset"; e.sel = 4'h0; exp_q.push_back(e);
    pop_check();
`ifdef BYPASS_PERF_CNT_EN
    check("perf_lu_rst", 64'(perf_load_use_cnt), 64'd0);
    check("perf_fwd_rst", 64'(perf_fwd_cnt), 64'd0);
`endif

    //     tag            v  rs1 rs2 rd  we ld fl ps lu  sel
    issue("add_x5",      1, 1,  2,  5,  1, 0, 0, 0, 0, 4'b0000);
    issue("add_x6_mem",  1, 5,  2,  6,  1, 0, 0, 0, 0, 4'b0010);
    issue("add_x7",      1, 1,  2,  7,  1, 0, 0, 0, 0, 4'b0000);
    issue("add_x8",      1, 1,  9,  8,  1, 0, 0, 0, 0, 4'b0000);
    issue("dist2_wb",    1, 2,  7,  10, 1, 0, 0, 0, 0, 4'b0100);
    issue("x7_a",        1, 1,  1,  7,  1, 0, 0, 0, 0, 4'b0000);
    issue("x7_b",        1, 1,  1,  7,  1, 0, 0, 0, 0, 4'b0000);
    issue("dbl_mem_win", 1, 2,  7,  11, 1, 0, 0, 0, 0, 4'b1000);
    issue("lw_x3",       1, 1,  2,  3,  1, 1, 0, 0, 0, 4'b0000);
    issue("lu_stall",    1, 3,  2,  4,  1, 0, 0, 0, 1, 4'b0000);
    issue("lu_resume",   1, 3,  2,  4,  1, 0, 0, 0, 0, 4'b0001);
    issue("prod_x0",     1, 1,  2,  0,  1, 0, 0, 0, 0, 4'b0000);
    issue("use_x0",      1, 0,  0,  12, 1, 0, 0, 0, 0, 4'b0000);
    issue("flush_x13",   1, 1,  2,  13, 1, 0, 1, 0, 0, 4'b0000);
    issue("use_x13",     1, 13, 13, 14, 1, 0, 0, 0, 0, 4'b0000);
    issue("nop_a",       0, 0,  0,  0,  0, 0, 0, 0, 0, 4'b0000);
    issue("lw_x15",      1, 1,  2,  15, 1, 1, 0, 0, 0, 4'b0000);
    issue("lu_flush",    1, 15, 2,  16, 1, 0, 1, 0, 1, 4'b0000);
    issue("nop_b",       0, 0,  0,  0,  0, 0, 0, 0, 0, 4'b0000);
    issue("add_x17",     1, 1,  2,  17, 1, 0, 0, 0, 0, 4'b0000);
    issue("add_x18",     1, 17, 17, 18, 1, 0, 0, 0, 0, 4'b1010);
    issue("hold_1",      1, 17, 18, 19, 1, 0, 0, 1, 0, 4'b1010);
    issue("hold_2_fl",   1, 17, 18, 19, 1, 0, 1, 1, 0, 4'b1010);
    issue("hold_3",      1, 17, 18, 19, 1, 0, 0, 1, 0, 4'b1010);
    issue("release",     1, 17, 18, 19, 1, 0, 0, 0, 0, 4'b1001);
    issue("nop_c",       0, 0,  0,  0,  0, 0, 0, 0, 0, 4'b0000);
    issue("add_x20",     1, 1,  2,  20, 1, 0, 0, 0, 0, 4'b0000);
    issue("add_x21",     1, 20, 2,  21, 1, 0, 0, 0, 0, 4'b0010);
`ifdef BYPASS_PERF_CNT_EN
    check("perf_lu", 64'(perf_load_use_cnt), 64'd2);
    check("perf_fwd", 64'(perf_fwd_cnt), 64'd9);
`endif

    rst = 1'b1;
    issue("rst_mid",     0, 0,  0,  0,  0, 0, 0, 1, 0, 4'b0000);
    rst = 1'b0;
`ifdef BYPASS_PERF_CNT_EN
    check("perf_lu_mid", 64'(perf_load_use_cnt), 64'd0);
    check("perf_fwd_mid", 64'(perf_fwd_cnt), 64'd0);
`endif
    issue("after_rst",   1, 20, 21, 22, 1, 0, 0, 0, 0, 4'b0000);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/operand_bypass_unit.md
Name: operand_bypass_unit

Overview:
- Parametrised successor to the single-operand forwarding mux, for the RV32 5-stage pipeline (IF/ID/EX/MEM/WB).
- Owns a tag pipeline of in-flight destination registers (EX, MEM, WB), detects load-use hazards, and registers the forwarding selects at the ID->EX boundary.
- Muxes XLEN-wide EX operand data for NUM_SRC source operands.
- Replaces the external forward-select computation and per-operand muxes.

Parameters:
- XLEN, 32, operand/result data width.
- NUM_SRC, 2, number of source operands bypassed (rs1, rs2, optional rs3); legal range 1..3.
- REG_AW, 5, register address width.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  valid instruction in ID.
- id_rs  in  NUM_SRC*REG_AW  ID source register addresses; operand i in bits [i*REG_AW +: REG_AW].
- id_rd  in  REG_AW  ID destination register.
- id_rd_we  in  1  ID instruction writes rd.
- id_is_load  in  1  ID instruction is a load.
- pipe_stall  in  1  external stall; freezes ID->EX and all tag stages.
- flush_ex  in  1  squash the instruction entering EX (branch redirect).
- ex_rs_data  in  NUM_SRC*XLEN  register-file operand data latched into EX.
- alu_result_mem  in  XLEN  MEM-stage result.
- result_wb  in  XLEN  WB-stage result.
- ex_op_data  out  NUM_SRC*XLEN  bypassed EX operands.
- forward_sel  out  NUM_SRC*2  per-operand forwardCtrl_e encoding (FORWARD_NONE=0, FORWARD_FROM_WB=1, FORWARD_FROM_MEM=2).
- load_use_stall  out  1  hazard stall request to IF/ID.

Behaviour:
- Tag stages EX, MEM, WB. Each stage holds {valid, rd, we, is_load}.
- Reset:
  - All stage valids clear to 0.
  - forward_sel = FORWARD_NONE for every operand.
  - load_use_stall = 0.
  - ex_op_data = ex_rs_data (combinational passthrough).
- Hazard detection, combinational:
  - load_use_stall = id_valid & EX.valid & EX.we & EX.is_load & EX.rd != 0 & (id_rs[i] == EX.rd for any i < NUM_SRC).
- Advance, when pipe_stall = 0:
  - WB <= MEM; MEM <= EX.
  - EX <= ID tag if id_valid & ~load_use_stall & ~flush_ex; otherwise EX <= bubble (valid = 0).
- Hold, when pipe_stall = 1:
  - All stages and forward_sel hold.
  - pipe_stall overrides flush_ex; a flush is only taken on a non-stalled cycle.
- forward_sel, registered at the same edge as the EX load:
  - Compare each id_rs[i] against the current EX entry (it becomes MEM next cycle) and the current MEM entry (it becomes WB next cycle).
  - Newest wins: an EX match gives FORWARD_FROM_MEM, else a MEM match gives FORWARD_FROM_WB, else FORWARD_NONE.
  - A match requires valid & we & rd != 0.
  - A bubble or flush loads FORWARD_NONE.
- Register x0 is never forwarded.
- The current WB entry is not forwarded from: the register file is write-first and supplies that value. Single-cycle latency from ID compare to EX select.
- ex_op_data[i], combinational mux on forward_sel[i]:
  - NONE gives ex_rs_data[i]; WB gives result_wb; MEM gives alu_result_mem.
  - An illegal code (3) gives ex_rs_data[i].
- Load in EX followed by a dependent instruction:
  - One stall cycle with a bubble in EX.
  - Next cycle the load is in MEM; the dependent instruction re-evaluates and gets FORWARD_FROM_WB when it enters EX (the load is then in WB).
- Simultaneous load_use_stall and flush_ex: the flush takes effect (bubble).
- rst mid-operation clears all tags regardless of pipe_stall.

Optional Feature:
- Macro: BYPASS_PERF_CNT_EN.
- Defined: adds outputs perf_load_use_cnt (32 bits) and perf_fwd_cnt (32 bits), both reset to 0.
  - perf_load_use_cnt increments on every cycle with load_use_stall = 1 and pipe_stall = 0.
  - perf_fwd_cnt increments by the number of operands whose newly registered forward_sel != FORWARD_NONE on each advance.
  - Both counters wrap at 2^32.
- Undefined: neither port nor counter exists; behaviour otherwise identical.

Test Plan:
- Reset with rst = 1 for 2 cycles, then release:
  - forward_sel = 0 for all operands, load_use_stall = 0.
  - ex_op_data equals ex_rs_data = 0x1234_5678.
- ALU back-to-back: issue add x5, then add x6 with rs1 = x5. When x6 is in EX, alu_result_mem = 0xDEAD_BEEF:
  - forward_sel[0] = FORWARD_FROM_MEM.
  - ex_op_data[0] = 0xDEAD_BEEF.
- Distance-2 dependency plus double match:
  - rs2 = x7 written two instructions earlier gives FORWARD_FROM_WB with result_wb = 0xCAFE_0001.
  - When both MEM and WB hold x7, MEM data wins.
- Load-use: lw x3, then add x4 reading x3:
  - load_use_stall = 1 for exactly 1 cycle and EX receives a bubble.
  - The dependent op then gets FORWARD_FROM_WB.
- x0 and flush:
  - A producer with rd = x0 never forwards (FORWARD_NONE).
  - flush_ex = 1 on a matching producer's ID->EX edge means no later forward from it.
- pipe_stall = 1 for 3 cycles mid-dependency:
  - forward_sel and tags hold.
  - Correct forward after release.
  - Under BYPASS_PERF_CNT_EN, counters match expected event counts.
